// File: rtl/key_pkg.sv
// Shared state encoding and default timing constants for the key conditioning path.
package key_pkg;

  typedef enum logic [1:0] {
    KS_RELEASED    = 2'd0,
    KS_PRESS_CHK   = 2'd1,
    KS_PRESSED     = 2'd2,
    KS_RELEASE_CHK = 2'd3
  } key_state_e;

  localparam int CLK_HZ           = 100_000_000;
  localparam int DEBOUNCE_DEFAULT = CLK_HZ / 50;  // 20 ms
  localparam int LONG_DEFAULT     = 3 * CLK_HZ;   // 3 s

endpackage

// File: rtl/key_debounce_lane.sv
// One key lane: two-flop synchronizer, debounce FSM, hold timer and registered
// level / press / release / long-press outputs.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// KS_RELEASED    | key accepted as up, waiting for synchronized high
// KS_PRESS_CHK   | high seen, counting stable cycles before accepting press
// KS_PRESSED     | key accepted as down, hold timer running
// KS_RELEASE_CHK | low seen while pressed, counting stable cycles, hold frozen
module key_debounce_lane
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES     = LONG_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [1:0]    r_sync;
  key_state_e    r_state;
  logic [DW-1:0] r_deb;
  logic [HW-1:0] r_hold;
  logic          r_fired;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_long;

  key_state_e    w_state_nxt;
  logic [DW-1:0] w_deb_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [HW-1:0] w_hold_inc;
  logic          w_fired_nxt;
  logic          w_level_nxt;
  logic          w_press_nxt;
  logic          w_release_nxt;
  logic          w_long_nxt;
  logic          w_s;

  assign w_s = r_sync[1];

  // Saturating hold count; the long pulse is launched on the edge that reaches the cap.
  assign w_hold_inc = (r_hold == HOLD_LAST) ? r_hold : r_hold + HW'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_deb_nxt     = r_deb;
    w_hold_nxt    = r_hold;
    w_fired_nxt   = r_fired;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    case (r_state)
      KS_RELEASED: begin
        if (w_s) begin
          w_state_nxt = KS_PRESS_CHK;
          w_deb_nxt   = '0;
        end
      end
      KS_PRESS_CHK: begin
        if (!w_s) begin
          w_state_nxt = KS_RELEASED;
        end else if (r_deb == DEB_LAST) begin
          w_state_nxt = KS_PRESSED;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
          w_hold_nxt  = '0;
          w_fired_nxt = 1'b0;
        end else begin
          w_deb_nxt = r_deb + DW'(1);
        end
      end
      KS_PRESSED: begin
        w_hold_nxt = w_hold_inc;
        if ((w_hold_inc == HOLD_LAST) && !r_fired) begin
          w_long_nxt  = 1'b1;
          w_fired_nxt = 1'b1;
        end
        if (!w_s) begin
          w_state_nxt = KS_RELEASE_CHK;
          w_deb_nxt   = '0;
        end
      end
      KS_RELEASE_CHK: begin
        if (w_s) begin
          w_state_nxt = KS_PRESSED;
        end else if (r_deb == DEB_LAST) begin
          w_state_nxt   = KS_RELEASED;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
          w_fired_nxt   = 1'b0;
        end else begin
          w_deb_nxt = r_deb + DW'(1);
        end
      end
      default: begin
        w_state_nxt = KS_RELEASED;
        w_deb_nxt   = '0;
        w_hold_nxt  = '0;
        w_fired_nxt = 1'b0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_state   <= KS_RELEASED;
      r_deb     <= '0;
      r_hold    <= '0;
      r_fired   <= 1'b0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key_raw};
      r_state   <= w_state_nxt;
      r_deb     <= w_deb_nxt;
      r_hold    <= w_hold_nxt;
      r_fired   <= w_fired_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

endmodule

// File: rtl/key_conditioner.sv
// Array of independent debounced key lanes feeding the power controller and menu logic.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES     = LONG_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_raw,
  output logic [NUM_KEYS-1:0] o_key_level,
  output logic [NUM_KEYS-1:0] o_key_press,
  output logic [NUM_KEYS-1:0] o_key_release,
  output logic [NUM_KEYS-1:0] o_key_long
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_key_raw(i_key_raw[g]),
      .o_level  (o_key_level[g]),
      .o_press  (o_key_press[g]),
      .o_release(o_key_release[g]),
      .o_long   (o_key_long[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/long timings.
module tb_key_conditioner;

  localparam int NK  = 5;
  localparam int DEB = 4;
  localparam int LNG = 20;

  typedef int cnt_t [NK];

  typedef struct {
    logic [4:0] raw;
    int         ncyc;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
    logic [4:0] lng;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   coincide = 0;
  cnt_t cnt_press, cnt_rel, cnt_long;
  cnt_t t_press, t_rel, t_long;
  cnt_t bp, br, bl;
  vec_t vecs [8];

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_key_raw    (key_raw),
    .o_key_level  (key_level),
    .o_key_press  (key_press),
    .o_key_release(key_release),
    .o_key_long   (key_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < NK; i++) begin
      cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0;
      t_press[i] = 0; t_rel[i] = 0; t_long[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      if (key_press[i])   begin cnt_press[i]++; t_press[i] = cyc; end
      if (key_release[i]) begin cnt_rel[i]++;   t_rel[i]   = cyc; end
      if (key_long[i])    begin cnt_long[i]++;  t_long[i]  = cyc; end
      if (key_press[i] && key_release[i]) coincide++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic snap();
    bp = cnt_press;
    br = cnt_rel;
    bl = cnt_long;
  endtask

  function automatic logic [9:0] dvec(input cnt_t now_c, input cnt_t base);
    logic [9:0] v;
    int d;
    v = '0;
    for (int i = 0; i < NK; i++) begin
      d = now_c[i] - base[i];
      v[2*i +: 2] = (d > 3) ? 2'd3 : 2'(d);
    end
    return v;
  endfunction

  function automatic logic [9:0] expand(input logic [4:0] m);
    logic [9:0] v;
    v = '0;
    for (int i = 0; i < NK; i++) v[2*i] = m[i];
    return v;
  endfunction

  initial begin
    int d0;
    int seen_both;
    int bad3;
    int lvl_drop;

    vecs[0] = '{5'h01,  3, 5'h00, 5'h00, 5'h00, 5'h00};
    vecs[1] = '{5'h00, 10, 5'h00, 5'h00, 5'h00, 5'h00};
    vecs[2] = '{5'h01,  5, 5'h00, 5'h00, 5'h00, 5'h00};
    vecs[3] = '{5'h00, 12, 5'h00, 5'h01, 5'h01, 5'h00};
    vecs[4] = '{5'h11, 10, 5'h11, 5'h11, 5'h00, 5'h00};
    vecs[5] = '{5'h00, 10, 5'h00, 5'h00, 5'h11, 5'h00};
    vecs[6] = '{5'h04,  8, 5'h04, 5'h04, 5'h00, 5'h00};
    vecs[7] = '{5'h00,  8, 5'h00, 5'h00, 5'h04, 5'h00};

    // Reset with all keys held; press lands after the 7th edge following release.
    rst_n   = 1'b0;
    key_raw = 5'h1f;
    step(3);
    chk("rst_level",   32'(key_level),   32'h0);
    chk("rst_press",   32'(key_press),   32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_long",    32'(key_long),    32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("rst_press_edge%0d", k), 32'(key_press), (k == 7) ? 32'h1f : 32'h0);
    end
    chk("rst_level_after", 32'(key_level), 32'h1f);
    key_raw = 5'h00;
    step(10);
    chk("rst_all_released", 32'(key_level), 32'h0);
    chk("rst_release_cnt0", 32'(cnt_rel[0]), 32'd1);

    // Table of level/pulse expectations per applied pattern.
    for (int r = 0; r < 8; r++) begin
      snap();
      key_raw = vecs[r].raw;
      step(vecs[r].ncyc);
      chk($sformatf("row%0d_level", r), 32'(key_level), 32'(vecs[r].lvl));
      chk($sformatf("row%0d_press", r), 32'(dvec(cnt_press, bp)), 32'(expand(vecs[r].prs)));
      chk($sformatf("row%0d_release", r), 32'(dvec(cnt_rel, br)), 32'(expand(vecs[r].rel)));
      chk($sformatf("row%0d_long", r), 32'(dvec(cnt_long, bl)), 32'(expand(vecs[r].lng)));
    end

    // Long press on lane 1.
    snap();
    key_raw = 5'h02;
    step(40);
    d0 = cyc;
    key_raw = 5'h00;
    step(12);
    chk("long_press_cnt",   32'(cnt_press[1] - bp[1]), 32'd1);
    chk("long_long_cnt",    32'(cnt_long[1] - bl[1]),  32'd1);
    chk("long_release_cnt", 32'(cnt_rel[1] - br[1]),   32'd1);
    chk("long_latency",     32'(t_long[1] - t_press[1]), 32'(LNG - 1));
    chk("long_rel_latency", 32'(t_rel[1] - d0), 32'd7);

    // Release bounce on lane 2 stretches the long-press latency.
    snap();
    lvl_drop = 0;
    key_raw = 5'h04;
    step(10);
    key_raw = 5'h00;
    step(1);
    if (!key_level[2]) lvl_drop++;
    step(1);
    if (!key_level[2]) lvl_drop++;
    key_raw = 5'h04;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (!key_level[2]) lvl_drop++;
    end
    chk("bounce_level_drops",  32'(lvl_drop), 32'd0);
    chk("bounce_release_cnt",  32'(cnt_rel[2] - br[2]), 32'd0);
    chk("bounce_long_cnt",     32'(cnt_long[2] - bl[2]), 32'd1);
    chk("bounce_long_latency", 32'(t_long[2] - t_press[2]), 32'(LNG - 1 + 2));
    key_raw = 5'h00;
    step(10);
    chk("bounce_final_release", 32'(cnt_rel[2] - br[2]), 32'd1);

    // Lanes 0 and 4 pressed together while lane 3 bounces every two cycles.
    snap();
    seen_both = 0;
    bad3 = 0;
    for (int k = 0; k < 12; k++) begin
      key_raw = {1'b1, ((k / 2) % 2 == 0), 2'b00, 1'b1};
      step(1);
      if (key_press == 5'h11) seen_both++;
      if (key_press[3] || key_level[3]) bad3++;
    end
    chk("indep_press_0_4", 32'(seen_both), 32'd1);
    chk("indep_lane3_quiet", 32'(bad3), 32'd0);
    key_raw = 5'h19;
    step(10);
    chk("indep_lane3_press", 32'(cnt_press[3] - bp[3]), 32'd1);
    chk("indep_lane0_press", 32'(cnt_press[0] - bp[0]), 32'd1);
    key_raw = 5'h00;
    step(10);
    chk("indep_released", 32'(key_level), 32'h0);

    // Reset 10 cycles into a hold on lane 1.
    key_raw = 5'h02;
    step(10);
    chk("midrst_level_before", 32'(key_level), 32'h02);
    rst_n = 1'b0;
    #1;
    chk("midrst_level_drop", 32'(key_level), 32'h0);
    step(2);
    snap();
    rst_n = 1'b1;
    step(10);
    chk("midrst_fresh_press", 32'(cnt_press[1] - bp[1]), 32'd1);
    chk("midrst_no_release",  32'(cnt_rel[1] - br[1]),   32'd0);
    chk("midrst_level_after", 32'(key_level), 32'h02);
    key_raw = 5'h00;
    step(10);

    chk("press_release_coincide", 32'(coincide), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Conditions the raw push-button inputs of the board and produces the clean signals that the gesture power controller and the mode/menu logic consume. Each of NUM_KEYS keys passes through a two-flop synchronizer and a per-key debounce state machine. Each key yields a debounced level plus single-cycle press, release and long-press pulses. The block sits between the board buttons and every key-driven control block; left_key/right_key of the power controller are driven from key_press of the corresponding lanes.

## Interface
- NUM_KEYS, 5, number of independent key lanes (1..16)
- DEBOUNCE_CYCLES, 2_000_000, consecutive stable synchronized cycles required to accept a level change (20 ms at 100 MHz); minimum 2
- LONG_CYCLES, 300_000_000, held cycles after press acceptance for a long-press pulse (3 s); must exceed DEBOUNCE_CYCLES
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- key_raw  input  NUM_KEYS  raw button levels, 1 = pressed, asynchronous to clk
- key_level  output  NUM_KEYS  debounced level per key
- key_press  output  NUM_KEYS  one-cycle pulse on accepted press
- key_release  output  NUM_KEYS  one-cycle pulse on accepted release
- key_long  output  NUM_KEYS  one-cycle pulse, at most once per hold

## Operation
- All lanes are independent and identical. No cross-key priority and no interaction between lanes.
- Synchronizer: two flops per lane. s = second-flop output.
- Per-lane FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. The debounce counter is deb_cnt, width $clog2(DEBOUNCE_CYCLES).
- RELEASED:
  - s=1: go to PRESS_CHK, deb_cnt←0.
- PRESS_CHK:
  - s=0: go to RELEASED. This is a glitch; no output.
  - s=1 and deb_cnt=DEBOUNCE_CYCLES-1: go to PRESSED. Set key_level←1 and key_press←1 for one cycle. Set hold_cnt←0 and long_fired←0.
  - Otherwise: deb_cnt++.
- PRESSED:
  - hold_cnt increments each cycle and saturates at LONG_CYCLES-1. Its width is $clog2(LONG_CYCLES).
  - When hold_cnt=LONG_CYCLES-1 and long_fired=0: key_long←1 for one cycle, long_fired←1.
  - s=0: go to RELEASE_CHK, deb_cnt←0. hold_cnt freezes.
- RELEASE_CHK:
  - s=1: return to PRESSED. hold_cnt resumes from its frozen value; long_fired is kept.
  - s=0 and deb_cnt=DEBOUNCE_CYCLES-1: go to RELEASED. Set key_level←0 and key_release←1 for one cycle. Clear long_fired.
  - Otherwise: deb_cnt++.
- Illegal state encoding: go to RELEASED with outputs low.
- Simultaneous events:
  - key_long and the PRESSED→RELEASE_CHK transition may occur in the same cycle. key_long is still emitted.
  - key_press and key_release never coincide on one lane.
  - Any combination may coincide across lanes.

## Timing
- Reset (reset=0), asynchronous:
  - All FSMs go to RELEASED and all counters to 0.
  - Synchronizer flops, key_level, key_press, key_release and key_long all go to 0.
- Reset mid-operation discards any in-progress debounce or hold. After release of reset, a held key is re-qualified as a fresh press.
- Press latency: with key_raw held high, key_press is high in the cycle following clock edge DEBOUNCE_CYCLES+3, counting the first edge that samples key_raw=1 as edge 1. key_level rises in the same cycle. Release latency is identical.
- Long-press latency: key_long asserts exactly LONG_CYCLES-1 cycles after key_press when there are no release glitches. Each RELEASE_CHK cycle adds one cycle to this.
- All outputs are registered. Pulses are exactly one clk cycle wide.

## Structure
- Package key_pkg contains the 2-bit state encoding (RELEASED=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3) and the default timing constants (DEBOUNCE_DEFAULT, LONG_DEFAULT, CLK_HZ=100_000_000).
- Sub-module key_debounce_lane holds one synchronizer, the FSM, deb_cnt, hold_cnt and long_fired. key_conditioner instantiates NUM_KEYS copies in a generate loop and concatenates their outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.

- Reset with key_raw=5'b11111 held through reset release: all outputs stay 0 during reset. key_press=5'b11111 is one cycle wide, 7 cycles after the first edge after release.
- Glitch rejection: pulse key_raw[0] high for 3 cycles, then low. There is no key_press and key_level[0] stays 0. A 5-cycle high pulse yields exactly one key_press[0].
- Long press: hold key_raw[1] for 40 cycles. Expect one key_press[1], one key_long[1] 19 cycles later, no second key_long, and one key_release[1] 7 cycles after key_raw drops.
- Release bounce: while lane 2 is PRESSED, drop key_raw[2] low for 2 cycles and then restore it. Expect no key_release, key_level[2]=1 throughout, and key_long delayed by the bounce duration.
- Independent lanes: press key 0 and key 4 simultaneously with key 3 bouncing. key_press shows 5'b10001 in one cycle, and lane 3 output follows only its own stable edges.
- Reset mid-hold: assert reset 10 cycles into a press on lane 1. All outputs drop immediately. After reset release with the key still held, a fresh press is produced and no key_release is emitted.
